// File: rtl/rf_arb_pkg.sv
// Shared types and default widths for the register-file write arbiter.
// Holds the output-stage state enum.
package rf_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } wr_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first valid index at or after rr_ptr.
// Purely combinational; wraps from NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               hit
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    sum   = '0;
    j     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // rr_ptr + i stays below 2*NUM_REQ, so one subtract wraps it
      sum = {1'b0, rr_ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ))
        sum = sum - (IW+1)'(NUM_REQ);
      j = sum[IW-1:0];
      if (!hit && valid[j]) begin
        hit      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/rf_wr_arb.sv
// Register-file write-back arbiter: round-robin pick into a
// single-entry output stage driving the RF write port.
module rf_wr_arb
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_wr_stall,
  output logic                          o_wr_en,
  output logic [ADDR_WIDTH-1:0]         o_wr_addr,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    o_wr_src
);

  localparam int IW = $clog2(NUM_REQ);

  wr_state_e     state_q, state_d;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;
  logic [IW-1:0] pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic          pick_hit;
  logic          can_accept;
  logic          xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .valid  (i_req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_gnt),
    .idx    (pick_idx),
    .hit    (pick_hit)
  );

  // Gated by reset so ready drops the instant reset asserts
  assign can_accept = i_rst_n &&
    ((state_q == EMPTY) || !i_wr_stall);
  assign xfer = can_accept && pick_hit;
  assign o_req_ready = can_accept ? pick_gnt : '0;

  assign o_wr_en = (state_q == FULL) && !i_wr_stall &&
    (|o_wr_addr);

  assign rr_ptr_d = (pick_idx == IW'(NUM_REQ-1)) ?
    '0 : pick_idx + IW'(1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL:  if (!i_wr_stall) state_d = xfer ? FULL : EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q  <= '0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_wr_src  <= '0;
    end else if (xfer) begin
      rr_ptr_q  <= rr_ptr_d;
      o_wr_addr <= i_req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
      o_wr_data <= i_req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
      o_wr_src  <= pick_idx;
    end
  end

endmodule

// File: tb/tb_rf_wr_arb.sv
// Bench for rf_wr_arb: per-cycle model compare plus directed
// scenarios with literal expectations.
module tb_rf_wr_arb;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    valid = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] data = '0;
  logic            stall = 1'b0;
  logic [N-1:0]    ready;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [IW-1:0]   wr_src;

  rf_wr_arb #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (valid),
    .i_req_addr  (addr),
    .i_req_data  (data),
    .o_req_ready (ready),
    .i_wr_stall  (stall),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_wr_src    (wr_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // Model: one held write slot plus a round-robin pointer
  bit            m_full = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            m_src = 0;
  int            m_ptr = 0;
  int            gnt_q[$];

  always @(negedge clk) begin : mon
    int g;
    logic [N-1:0] er;
    logic ewe;
    bit acc;
    if (!rst_n) begin
      m_full = 0; m_addr = '0; m_data = '0;
      m_src = 0; m_ptr = 0;
      chk("rst_ready", 64'(ready), 64'(0));
      chk("rst_wr_en", 64'(wr_en), 64'(0));
      chk("rst_addr", 64'(wr_addr), 64'(0));
      chk("rst_data", 64'(wr_data), 64'(0));
      chk("rst_src", 64'(wr_src), 64'(0));
    end else begin
      acc = !m_full || !stall;
      g = pick(valid, m_ptr);
      er = '0;
      if (acc && g >= 0) er[g] = 1'b1;
      ewe = m_full && !stall && (m_addr != 0);
      chk("ready", 64'(ready), 64'(er));
      chk("wr_en", 64'(wr_en), 64'(ewe));
      chk("wr_addr", 64'(wr_addr), 64'(m_addr));
      chk("wr_data", 64'(wr_data), 64'(m_data));
      chk("wr_src", 64'(wr_src), 64'(m_src));
      if (m_full && !stall) m_full = 0;
      if (acc && g >= 0) begin
        m_full = 1;
        m_addr = addr[g*AW +: AW];
        m_data = data[g*DW +: DW];
        m_src  = g;
        m_ptr  = (g + 1) % N;
        gnt_q.push_back(g);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(int k, logic [AW-1:0] a, logic [DW-1:0] d);
    addr[k*AW +: AW] = a;
    data[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0;
    stall = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int exp_g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    do_reset();

    // single request, latency 1
    set_req(0, 5'd3, 32'hDEAD_BEEF);
    valid = 4'b0001;
    settle();
    chk("s34_ready", 64'(ready), 64'(4'b0001));
    step();
    valid = '0;
    settle();
    chk("s34_wr_en", 64'(wr_en), 64'(1));
    chk("s34_addr", 64'(wr_addr), 64'(3));
    chk("s34_data", 64'(wr_data), 64'hDEAD_BEEF);
    chk("s34_src", 64'(wr_src), 64'(0));
    step();

    // all four requesting: strict rotation
    do_reset();
    for (int k = 0; k < N; k++)
      set_req(k, AW'(k + 1), 32'h100 + 32'(k));
    valid = 4'b1111;
    gnt_q.delete();
    for (int c = 0; c < 8; c++) begin
      settle();
      chk("s35_ready", 64'(ready), 64'(1) << exp_g[c]);
      if (c > 0) chk("s35_wr_en", 64'(wr_en), 64'(1));
      step();
    end
    valid = '0;
    settle();
    chk("s35_last_wr", 64'(wr_en), 64'(1));
    chk("s35_gnt_n", 64'(gnt_q.size()), 64'(8));
    for (int c = 0; c < 8 && c < gnt_q.size(); c++)
      chk("s35_model_gnt", 64'(gnt_q[c]), 64'(exp_g[c]));
    step();

    // stall holds the output stage
    do_reset();
    set_req(0, 5'd7, 32'hAAAA_0007);
    set_req(1, 5'd9, 32'hBBBB_0009);
    valid = 4'b0001;
    step();
    valid = 4'b0010;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("s36_hold_addr", 64'(wr_addr), 64'(7));
      chk("s36_hold_ready", 64'(ready), 64'(0));
      chk("s36_hold_wr_en", 64'(wr_en), 64'(0));
      step();
    end
    stall = 1'b0;
    settle();
    chk("s36_rel_wr_en", 64'(wr_en), 64'(1));
    chk("s36_rel_ready", 64'(ready), 64'(4'b0010));
    step();
    valid = '0;
    settle();
    chk("s36_next_addr", 64'(wr_addr), 64'(9));
    chk("s36_next_src", 64'(wr_src), 64'(1));
    step();

    // address 0 is consumed silently
    do_reset();
    set_req(0, 5'd0, 32'h1234);
    set_req(1, 5'd4, 32'h4444);
    valid = 4'b0001;
    settle();
    chk("s37_ready", 64'(ready), 64'(1));
    step();
    valid = '0;
    settle();
    chk("s37_wr_en", 64'(wr_en), 64'(0));
    chk("s37_data", 64'(wr_data), 64'h1234);
    step();
    valid = 4'b0011;
    settle();
    chk("s37_ptr_adv", 64'(ready), 64'(4'b0010));
    step();
    valid = '0;
    step();

    // wrap from requester 3 to 0
    do_reset();
    for (int k = 0; k < N; k++)
      set_req(k, AW'(k + 10), 32'h300 + 32'(k));
    for (int k = 0; k < 3; k++) begin
      valid = '0;
      valid[k] = 1'b1;
      step();
    end
    valid = 4'b1001;
    settle();
    chk("s38_gnt3", 64'(ready), 64'(4'b1000));
    step();
    valid = 4'b0001;
    settle();
    chk("s38_gnt0", 64'(ready), 64'(4'b0001));
    chk("s38_src3", 64'(wr_src), 64'(3));
    step();
    valid = '0;
    step();

    // reset while a write is held
    set_req(0, 5'd5, 32'h5555);
    valid = 4'b0001;
    step();
    valid = '0;
    settle();
    chk("s39_pre_wr_en", 64'(wr_en), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("s39_rst_wr_en", 64'(wr_en), 64'(0));
    chk("s39_rst_addr", 64'(wr_addr), 64'(0));
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("s39_no_stale", 64'(wr_en), 64'(0));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
